// File: rtl/control_riesgos.sv
// control_riesgos: prioritized pipeline sequencing controller.
// Merges load-use hazard detection, multi-cycle data-memory wait and
// taken-branch flush into one FSM. It drives the stage enables, the ID/EX
// bubble mux and the IF/ID flush, and counts stalled cycles.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_ra_dec, i_re_a_dec    Decode source A and its active-low read enable
//   i_rb_dec, i_re_b_dec    Decode source B and its active-low read enable
//   i_rd_exe                Execute destination register
//   i_mem_re_exe            active-low; 0 = Execute instruction is a load
//   i_branch_taken_exe      taken branch/jump resolved in Execute
//   i_mem_req_mem           Memory-stage instruction accesses data memory
//   o_*_en_c                combinational PC / IF_ID / ID_EX / EX_MEM enables
//   o_nop_mux_c             1 = bubble into ID/EX
//   o_flush_if_id_c         1 = IF/ID captures a NOP
//   o_wb_nop_c              1 = MEM/WB captures a bubble
//   o_stall_cnt             registered saturating count of cycles with PC_EN=0
module control_riesgos #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_ra_dec,
    input  logic        i_re_a_dec,
    input  logic [3:0]  i_rb_dec,
    input  logic        i_re_b_dec,
    input  logic [3:0]  i_rd_exe,
    input  logic        i_mem_re_exe,
    input  logic        i_branch_taken_exe,
    input  logic        i_mem_req_mem,
    output logic        o_pc_en_c,
    output logic        o_if_id_en_c,
    output logic        o_id_ex_en_c,
    output logic        o_ex_mem_en_c,
    output logic        o_nop_mux_c,
    output logic        o_flush_if_id_c,
    output logic        o_wb_nop_c,
    output logic [15:0] o_stall_cnt
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STALL_W  = 16;
    // Wait-counter preload; the detection cycle and the release cycle are
    // not counted, hence MEM_LAT-2.
    localparam int unsigned CNT_INIT = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic        LONG_MEM = (MEM_LAT > 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_pend_flush;
    logic                 w_pend_flush_nxt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic                 w_hazard;
    logic                 w_mem_stall;

    // Load-use: Execute load writes a register Decode is about to read.
    assign w_hazard = ~i_mem_re_exe &
                      ((~i_re_a_dec & (i_ra_dec == i_rd_exe)) |
                       (~i_re_b_dec & (i_rb_dec == i_rd_exe)));

    // Single-cycle memory never needs a wait.
    assign w_mem_stall = i_mem_req_mem & LONG_MEM;

    // Next-state and combinational output decode.
    always_comb begin
        o_pc_en_c        = 1'b1;
        o_if_id_en_c     = 1'b1;
        o_id_ex_en_c     = 1'b1;
        o_ex_mem_en_c    = 1'b1;
        o_nop_mux_c      = 1'b0;
        o_flush_if_id_c  = 1'b0;
        o_wb_nop_c       = 1'b0;
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pend_flush_nxt = r_pend_flush;

        if (i_rst) begin
            o_pc_en_c       = 1'b0;
            o_if_id_en_c    = 1'b0;
            o_id_ex_en_c    = 1'b0;
            o_ex_mem_en_c   = 1'b0;
            o_nop_mux_c     = 1'b1;
            o_flush_if_id_c = 1'b1;
            o_wb_nop_c      = 1'b1;
            w_state_nxt     = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        o_pc_en_c     = 1'b0;
                        o_if_id_en_c  = 1'b0;
                        o_id_ex_en_c  = 1'b0;
                        o_ex_mem_en_c = 1'b0;
                        o_wb_nop_c    = 1'b1;
                        w_cnt_nxt     = CNT_W'(CNT_INIT);
                        w_state_nxt   = ST_MEM_WAIT;
                    end else if (i_branch_taken_exe) begin
                        o_flush_if_id_c = 1'b1;
                        o_nop_mux_c     = 1'b1;
                        w_state_nxt     = ST_FLUSH;
                    end else if (w_hazard) begin
                        o_pc_en_c    = 1'b0;
                        o_if_id_en_c = 1'b0;
                        o_nop_mux_c  = 1'b1;
                    end
                end

                ST_MEM_WAIT: begin
                    if (r_cnt != '0) begin
                        o_pc_en_c     = 1'b0;
                        o_if_id_en_c  = 1'b0;
                        o_id_ex_en_c  = 1'b0;
                        o_ex_mem_en_c = 1'b0;
                        o_wb_nop_c    = 1'b1;
                        w_cnt_nxt     = r_cnt - CNT_W'(1);
                    end else if (r_pend_flush) begin
                        // Deferred second wrong-path slot of an earlier branch.
                        o_flush_if_id_c  = 1'b1;
                        w_pend_flush_nxt = 1'b0;
                        w_state_nxt      = ST_RUN;
                    end else if (i_branch_taken_exe) begin
                        o_flush_if_id_c = 1'b1;
                        o_nop_mux_c     = 1'b1;
                        w_state_nxt     = ST_FLUSH;
                    end else if (w_hazard) begin
                        o_pc_en_c    = 1'b0;
                        o_if_id_en_c = 1'b0;
                        o_nop_mux_c  = 1'b1;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end

                ST_FLUSH: begin
                    // Execute holds a bubble, so branch and hazard are moot.
                    if (w_mem_stall) begin
                        o_pc_en_c        = 1'b0;
                        o_if_id_en_c     = 1'b0;
                        o_id_ex_en_c     = 1'b0;
                        o_ex_mem_en_c    = 1'b0;
                        o_wb_nop_c       = 1'b1;
                        w_cnt_nxt        = CNT_W'(CNT_INIT);
                        w_pend_flush_nxt = 1'b1;
                        w_state_nxt      = ST_MEM_WAIT;
                    end else begin
                        o_flush_if_id_c = 1'b1;
                        w_state_nxt     = ST_RUN;
                    end
                end

                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State, wait counter, pending flush and saturating stall counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_pend_flush <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend_flush <= w_pend_flush_nxt;
            if (!o_pc_en_c && (r_stall_cnt != {STALL_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_control_riesgos.sv
// Self-checking bench for control_riesgos (MEM_LAT=3): each cycle's expected
// output vector and stall count are queued when stimulus is driven and
// compared when the outputs are sampled mid-cycle.
module tb_control_riesgos;

    localparam int unsigned LAT = 3;

    // Output vector order: {pc, if_id, id_ex, ex_mem, nop_mux, flush, wb_nop}
    localparam logic [6:0] V_NORM   = 7'b1111_000;
    localparam logic [6:0] V_STALL  = 7'b0000_001;
    localparam logic [6:0] V_BUBBLE = 7'b0011_100;
    localparam logic [6:0] V_BRANCH = 7'b1111_110;
    localparam logic [6:0] V_FLUSH  = 7'b1111_010;
    localparam logic [6:0] V_RST    = 7'b0000_111;

    typedef struct {
        string       tag;
        logic [6:0]  outs;
        logic [15:0] stall;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  ra_dec, rb_dec, rd_exe;
    logic        re_a_dec, re_b_dec, mem_re_exe, branch_taken_exe, mem_req_mem;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, nop_mux, flush_if_id, wb_nop;
    logic [15:0] stall_cnt;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_errors;
    int          exp_stall;

    control_riesgos #(.MEM_LAT(LAT)) u_dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_ra_dec           (ra_dec),
        .i_re_a_dec         (re_a_dec),
        .i_rb_dec           (rb_dec),
        .i_re_b_dec         (re_b_dec),
        .i_rd_exe           (rd_exe),
        .i_mem_re_exe       (mem_re_exe),
        .i_branch_taken_exe (branch_taken_exe),
        .i_mem_req_mem      (mem_req_mem),
        .o_pc_en_c          (pc_en),
        .o_if_id_en_c       (if_id_en),
        .o_id_ex_en_c       (id_ex_en),
        .o_ex_mem_en_c      (ex_mem_en),
        .o_nop_mux_c        (nop_mux),
        .o_flush_if_id_c    (flush_if_id),
        .o_wb_nop_c         (wb_nop),
        .o_stall_cnt        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle (called just after a falling edge), queue the
    // expectation, sample mid-cycle, then advance to the next falling edge.
    task automatic step(input string tag, input logic r,
                        input logic [3:0] ra, input logic rea_n,
                        input logic [3:0] rb, input logic reb_n,
                        input logic [3:0] rd, input logic load_n,
                        input logic br, input logic mreq,
                        input logic [6:0] exp_outs);
        exp_t e;
        exp_t got_e;
        rst = r; ra_dec = ra; re_a_dec = rea_n; rb_dec = rb; re_b_dec = reb_n;
        rd_exe = rd; mem_re_exe = load_n; branch_taken_exe = br; mem_req_mem = mreq;
        e.tag = tag; e.outs = exp_outs; e.stall = 16'(exp_stall);
        sb_q.push_back(e);
        // Stall count model for the coming clock edge.
        if (r) exp_stall = 0;
        else if (!exp_outs[6] && exp_stall < 65535) exp_stall++;
        #2;
        got_e = sb_q.pop_front();
        chk({got_e.tag, ".outs"},
            32'({pc_en, if_id_en, id_ex_en, ex_mem_en, nop_mux, flush_if_id, wb_nop}),
            32'(got_e.outs));
        chk({got_e.tag, ".stall"}, 32'(stall_cnt), 32'(got_e.stall));
        @(negedge clk);
    endtask

    // Idle cycle: no load, no branch, no memory access.
    task automatic idle(input string tag, input logic [6:0] exp_outs);
        step(tag, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, exp_outs);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; exp_stall = 0;
        rst = 1'b1; ra_dec = '0; rb_dec = '0; rd_exe = '0;
        re_a_dec = 1'b1; re_b_dec = 1'b1; mem_re_exe = 1'b1;
        branch_taken_exe = 1'b0; mem_req_mem = 1'b0;
        @(negedge clk);

        // Reset outputs
        step("rst0", 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_RST);
        step("rst1", 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, V_RST);
        idle("post_rst", V_NORM);

        // Load-use via Rb, then the same with Rb not read
        step("lu_rb", 1'b0, 4'd5, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, V_BUBBLE);
        idle("lu_after", V_NORM);
        step("lu_rb_off", 1'b0, 4'd5, 1'b0, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, V_NORM);
        step("lu_ra", 1'b0, 4'd3, 1'b0, 4'd9, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, V_BUBBLE);
        step("lu_r0", 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, V_BUBBLE);
        step("no_load", 1'b0, 4'd3, 1'b0, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, V_NORM);

        // Memory wait: LAT-1 full stalls, then release with request ignored
        for (int i = 0; i < int'(LAT) - 1; i++)
            step("mem_stall", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_STALL);
        step("mem_rel", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_NORM);
        idle("mem_after", V_NORM);

        // Branch wins over hazard; FLUSH ignores branch and hazard
        step("br_hz", 1'b0, 4'd2, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, V_BRANCH);
        step("br_flush", 1'b0, 4'd2, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, V_FLUSH);
        idle("br_after", V_NORM);

        // Memory stall inside FLUSH defers the second flush slot
        step("bm_br", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, V_BRANCH);
        for (int i = 0; i < int'(LAT) - 1; i++)
            step("bm_stall", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_STALL);
        step("bm_rel", 1'b0, 4'd1, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, V_FLUSH);
        idle("bm_after", V_NORM);

        // Branch and hazard evaluated on a plain release cycle
        for (int i = 0; i < int'(LAT) - 1; i++)
            step("rb_stall", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_STALL);
        step("rb_rel_br", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, V_BRANCH);
        idle("rb_flush", V_FLUSH);
        for (int i = 0; i < int'(LAT) - 1; i++)
            step("rh_stall", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_STALL);
        step("rh_rel_hz", 1'b0, 4'd7, 1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, V_BUBBLE);
        idle("rh_after", V_NORM);

        // Reset during MEM_WAIT aborts it
        step("rm_req", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_STALL);
        step("rm_wait", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_STALL);
        step("rm_rst", 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, V_RST);
        idle("rm_after", V_NORM);

        // Reset during FLUSH aborts it
        step("rf_br", 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, V_BRANCH);
        step("rf_rst", 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, V_RST);
        idle("rf_after", V_NORM);

        // Saturation: hold a load-use hazard for 70000 cycles
        rst = 1'b0; ra_dec = 4'd4; re_a_dec = 1'b0; rb_dec = 4'd0; re_b_dec = 1'b1;
        rd_exe = 4'd4; mem_re_exe = 1'b0; branch_taken_exe = 1'b0; mem_req_mem = 1'b0;
        repeat (70000) @(negedge clk);
        exp_stall = (exp_stall + 70000 > 65535) ? 65535 : exp_stall + 70000;
        step("sat0", 1'b0, 4'd4, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, V_BUBBLE);
        step("sat1", 1'b0, 4'd4, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, V_BUBBLE);
        chk("sat_value", 32'(stall_cnt), 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
